if_fetch_ctrl: RTL and testbench

- Sequences instruction fetch for the IF stage over the AXI4 read channels (AR/R) to instruction memory.
- Takes a fetch request and PC address from IF, issues one single-beat AXI read, and returns the instruction word.
- Holds the pipeline stalled (PC and IF/ID writes) while a fetch is outstanding.
- Handles branch flushes mid-transaction by draining and discarding the stale response.

---
 rtl/if_axi_pkg.sv | 22 ++
 rtl/if_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/if_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_axi_pkg
// Brief    : Shared fetch FSM state encoding and AXI4 read-channel constants.
// Revision : 1.0 - initial release
// ============================================================================
package if_axi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        DROP = 3'd3,
        DONE = 3'd4
    } fetch_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Brief    : IF-stage instruction fetch sequencer over AXI4 AR/R channels,
//            single outstanding read, flush-safe response draining.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl
    import if_axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MASTER_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              flush,
    output logic              if_stall,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              fetch_err,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);

    fetch_state_t      r_state;
    logic              r_drop;
    logic              r_err_q;
    logic              r_arvalid;
    logic              r_rready;
    logic [ADDR_W-1:0] r_araddr;
    logic [DATA_W-1:0] r_instr;

    logic              w_ar_hs;
    logic              w_r_last_hs;
    logic              w_unused;

    assign w_ar_hs     = r_arvalid && ARREADY;
    assign w_r_last_hs = RVALID && r_rready && RLAST;
    // Only one read is ever outstanding, so the returned ID carries no information.
    assign w_unused    = ^RID;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_drop    <= 1'b0;
            r_err_q   <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_araddr  <= '0;
            r_instr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_req) begin
                        r_araddr  <= fetch_addr;
                        r_arvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    // AR cannot be withdrawn once raised; a flush is remembered instead.
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= (r_drop || flush) ? DROP : DATA;
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_r_last_hs) begin
                        r_rready <= 1'b0;
                        if (flush) begin
                            r_state <= IDLE;
                        end else begin
                            r_instr <= RDATA;
                            r_err_q <= (RRESP != RESP_OKAY);
                            r_state <= DONE;
                        end
                    end else if (flush) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (RVALID && RLAST) begin
                        r_rready <= 1'b0;
                        r_drop   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_drop    <= 1'b0;
                end
            endcase
        end
    end

    // Stall drops in DONE so the PC advances in the same cycle the word is delivered.
    assign if_stall    = ((r_state == IDLE) && fetch_req) ||
                         (r_state == ADDR) || (r_state == DATA) || (r_state == DROP);
    assign instr_valid = (r_state == DONE) && !flush;
    assign fetch_err   = instr_valid && r_err_q;
    assign instr_out   = r_instr;

    assign ARID    = ID_W'(MASTER_ID);
    assign ARADDR  = r_araddr;
    assign ARLEN   = 8'd0;
    assign ARSIZE  = SIZE_4B;
    assign ARBURST = BURST_INCR;
    assign ARVALID = r_arvalid;
    assign RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_ctrl
// Brief    : Scoreboard bench for if_fetch_ctrl with a programmable AXI slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        flush;
    logic        if_stall;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fetch_err;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MASTER_ID(0)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .flush(flush), .if_stall(if_stall), .instr_out(instr_out),
        .instr_valid(instr_valid), .fetch_err(fetch_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    int          ar_wait = 0;
    int          r_wait  = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    // AXI slave: presents ARREADY / R beat at negedges after configurable waits.
    initial begin : slave
        bit r_pend = 0;
        int ar_cnt = 0;
        int r_cnt  = 0;
        ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0; RRESP = '0; RID = '0;
        forever begin
            @(negedge clk);
            if (ARREADY) begin
                r_pend = 1;
                ar_cnt = 0;
                if (exp_addr.size() > 0) void'(exp_addr.pop_front());
            end
            if (RVALID) begin
                r_pend = 0;
                r_cnt  = 0;
            end
            ARREADY = 0; RVALID = 0; RLAST = 0;
            if (rst) begin
                r_pend = 0; ar_cnt = 0; r_cnt = 0;
            end else if (r_pend) begin
                if (r_cnt >= r_wait) begin
                    RVALID = 1; RLAST = 1; RDATA = s_rdata; RRESP = s_rresp;
                end else begin
                    r_cnt++;
                end
            end else if (ARVALID) begin
                if (exp_addr.size() > 0) chk("araddr", ARADDR, exp_addr[0]);
                else chk("unexpected_ar", 32'(ARVALID), 32'd0);
                if (ar_cnt >= ar_wait) ARREADY = 1;
                else ar_cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an instruction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(instr_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_out", instr_out, e.data);
                    chk("fetch_err", 32'(fetch_err), 32'(e.err));
                    chk("valid_cycle", cyc, e.cyc);
                end
            end else if (fetch_err) begin
                chk("err_without_valid", 32'(fetch_err), 32'd0);
            end
        end
    end

    task automatic run_fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                             input int arw, input int rw, input int fl_at, input bit dv, input int lat);
        int t0;
        @(negedge clk);
        ar_wait = arw; r_wait = rw; s_rdata = d; s_rresp = resp;
        fetch_addr = a;
        fetch_req  = 1;
        exp_addr.push_back(a);
        t0 = cyc;
        if (dv) exp_q.push_back('{data: d, err: (resp != 2'b00), cyc: t0 + lat});
        #1 chk("stall_t0", 32'(if_stall), 32'd1);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            fetch_req = 0;
            flush     = (k == fl_at);
            #1;
            if (k == 1) chk("arvalid_t1", 32'(ARVALID), 32'd1);
            if (dv) chk("stall", 32'(if_stall), 32'(k < lat));
            else if (k == lat + 1) chk("stall_idle", 32'(if_stall), 32'd0);
        end
        flush = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst = 1; fetch_req = 0; fetch_addr = '0; flush = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_arvalid", 32'(ARVALID), 32'd0);
        chk("rst_rready",  32'(RREADY), 32'd0);
        chk("rst_araddr",  ARADDR, 32'd0);
        chk("rst_instr",   instr_out, 32'd0);
        chk("rst_valid",   32'(instr_valid), 32'd0);
        chk("rst_stall",   32'(if_stall), 32'd0);
        chk("const_arid",  32'(ARID), 32'd0);
        chk("const_arlen", 32'(ARLEN), 32'd0);
        chk("const_arsize", 32'(ARSIZE), 32'd2);
        chk("const_arburst", 32'(ARBURST), 32'd1);
        rst = 0;

        run_fetch(32'h10, 32'h13,       2'b00, 0, 0, 0, 1, 3);
        run_fetch(32'h14, 32'h00500093, 2'b00, 3, 2, 0, 1, 8);
        run_fetch(32'h18, 32'hDEADBEEF, 2'b00, 3, 0, 2, 0, 6);
        run_fetch(32'h20, 32'h22,       2'b00, 0, 0, 0, 1, 3);
        run_fetch(32'h24, 32'h55,       2'b00, 0, 0, 2, 0, 3);
        chk("flush_keeps_instr", instr_out, 32'h22);
        run_fetch(32'h28, 32'h1234,     2'b10, 0, 0, 0, 1, 3);

        // Asynchronous reset while the R beat is being presented in DATA.
        @(negedge clk);
        ar_wait = 0; r_wait = 0; s_rdata = 32'h99; s_rresp = 2'b00;
        fetch_addr = 32'h2C; fetch_req = 1;
        exp_addr.push_back(32'h2C);
        @(negedge clk);
        fetch_req = 0;
        @(negedge clk);
        #1 chk("data_rready", 32'(RREADY), 32'd1);
        rst = 1;
        #1;
        chk("arst_arvalid", 32'(ARVALID), 32'd0);
        chk("arst_rready",  32'(RREADY), 32'd0);
        chk("arst_araddr",  ARADDR, 32'd0);
        chk("arst_instr",   instr_out, 32'd0);
        chk("arst_valid",   32'(instr_valid), 32'd0);
        chk("arst_err",     32'(fetch_err), 32'd0);
        chk("arst_stall",   32'(if_stall), 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;
        run_fetch(32'h30, 32'h77, 2'b00, 0, 0, 0, 1, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("ar_queue_empty", 32'(exp_addr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
